// File: rtl/ro_puf_counter_ctrl_pkg.sv
// Shared definitions for the RO PUF responder: state encodings and defaults.
// The state encodings are shared with the PUF controller, which treats 2'b11 as "done".
package ro_puf_counter_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_COUNT   = 2'b01,
      ST_RELEASE = 2'b10,
      ST_DONE    = 2'b11
   } state_t;

   localparam int DEF_CNT_W    = 16;
   localparam int DEF_TERMINAL = 1000;
   localparam int DEF_TMO_W    = 20;
   localparam int DEF_TIMEOUT  = 500000;

endpackage

// File: rtl/ro_edge_sync.sv
// Two-flop synchronizer followed by a rising-edge detector for one
// ring-oscillator output. Produces at most one pulse per clk.
module ro_edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise
);

   logic sync_q1;
   logic sync_q2;
   logic sync_d;

   // Metastability filter, then one extra flop to spot the 0->1 transition
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
         sync_d  <= 1'b0;
      end else begin
         sync_q1 <= din;
         sync_q2 <= sync_q1;
         sync_d  <= sync_q2;
      end
   end

   assign rise = sync_q2 & ~sync_d;

endmodule

// File: rtl/ro_puf_counter_ctrl.sv
// RO PUF responder: races two ring oscillators while roen is high and
// publishes one response bit, signalling completion with state 2'b11.
// Optional macro RO_PUF_TIE_FLAG_EN adds a registered 'tie' output.
module ro_puf_counter_ctrl
   import ro_puf_counter_ctrl_pkg::*;
#(
   parameter int CNT_W    = DEF_CNT_W,
   parameter int TERMINAL = DEF_TERMINAL,
   parameter int TMO_W    = DEF_TMO_W,
   parameter int TIMEOUT  = DEF_TIMEOUT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       roen,
   input  logic       ro_a,
   input  logic       ro_b,
   output logic [1:0] counter_ctrl_state,
   output logic       resp_bit,
   output logic       timeout
`ifdef RO_PUF_TIE_FLAG_EN
   ,
   output logic       tie
`endif
);

   localparam logic [CNT_W-1:0] TERM_V   = CNT_W'(TERMINAL);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   state_t           state;
   state_t           state_nxt;
   logic             rise_a;
   logic             rise_b;
   logic [CNT_W-1:0] cnt_a;
   logic [CNT_W-1:0] cnt_b;
   logic [TMO_W-1:0] tmo;
   logic             hit_term;
   logic             hit_tmo;
   logic             finish;

   // Saturating increments: counters stick at all-ones rather than wrap
   function automatic logic [CNT_W-1:0] inc_cnt(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   function automatic logic [TMO_W-1:0] inc_tmo(input logic [TMO_W-1:0] v);
      return (&v) ? v : v + TMO_W'(1);
   endfunction

   ro_edge_sync u_sync_a (.clk(clk), .rst(rst), .din(ro_a), .rise(rise_a));
   ro_edge_sync u_sync_b (.clk(clk), .rst(rst), .din(ro_b), .rise(rise_b));

   assign hit_term = (cnt_a >= TERM_V) || (cnt_b >= TERM_V);
   assign hit_tmo  = (tmo == TMO_LAST);

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic; abort wins, then terminal, then timeout
   always_comb begin
      state_nxt = state;
      finish    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (roen) state_nxt = ST_COUNT;
         end
         ST_COUNT: begin
            if (!roen) begin
               state_nxt = ST_IDLE;
            end else if (hit_term || hit_tmo) begin
               state_nxt = ST_DONE;
               finish    = 1'b1;
            end
         end
         ST_DONE: begin
            state_nxt = ST_RELEASE;
         end
         ST_RELEASE: begin
            if (!roen) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Edge and cycle counters: cleared in IDLE, advancing only in COUNT
   always_ff @(posedge clk) begin
      if (rst || state == ST_IDLE) begin
         cnt_a <= '0;
         cnt_b <= '0;
         tmo   <= '0;
      end else if (state == ST_COUNT) begin
         if (rise_a) cnt_a <= inc_cnt(cnt_a);
         if (rise_b) cnt_b <= inc_cnt(cnt_b);
         tmo <= inc_tmo(tmo);
      end
   end

   // Response capture on the COUNT->DONE transition; held otherwise
   always_ff @(posedge clk) begin
      if (rst) begin
         resp_bit <= 1'b0;
         timeout  <= 1'b0;
      end else if (finish) begin
         resp_bit <= (cnt_a > cnt_b);
         timeout  <= ~hit_term;
      end
   end

`ifdef RO_PUF_TIE_FLAG_EN
   // Tie flag captured alongside the response bit
   always_ff @(posedge clk) begin
      if (rst)         tie <= 1'b0;
      else if (finish) tie <= (cnt_a == cnt_b);
   end
`endif

   assign counter_ctrl_state = state;

endmodule

// File: tb/tb_ro_puf_counter_ctrl.sv
// Self-checking bench for ro_puf_counter_ctrl. Define RO_PUF_TIE_FLAG_EN
// to also exercise the optional tie output.
module tb_ro_puf_counter_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       roen = 1'b0;
   logic       roen2 = 1'b0;
   logic       ro_a = 1'b0;
   logic       ro_b = 1'b0;
   logic [1:0] st1, st2;
   logic       resp1, resp2, tmo1, tmo2;
`ifdef RO_PUF_TIE_FLAG_EN
   logic       tie1, tie2;
`endif

   int n_checks = 0;
   int n_err    = 0;
   int pa = 0, pb = 0, ph_a = 0, ph_b = 0;
   int done_cnt = 0;

   typedef struct {
      int pa;
      int pb;
      bit resp;
      bit tmo;
   } vec_t;

   typedef struct {
      bit resp;
      bit tmo;
   } exp_t;

   exp_t sb[$];
   vec_t tbl[6];

   ro_puf_counter_ctrl #(.CNT_W(16), .TERMINAL(20), .TMO_W(20), .TIMEOUT(300)) dut1 (
      .clk(clk), .rst(rst), .roen(roen), .ro_a(ro_a), .ro_b(ro_b),
      .counter_ctrl_state(st1), .resp_bit(resp1), .timeout(tmo1)
`ifdef RO_PUF_TIE_FLAG_EN
      , .tie(tie1)
`endif
   );

   ro_puf_counter_ctrl #(.CNT_W(16), .TERMINAL(20), .TMO_W(20), .TIMEOUT(50)) dut2 (
      .clk(clk), .rst(rst), .roen(roen2), .ro_a(ro_a), .ro_b(ro_b),
      .counter_ctrl_state(st2), .resp_bit(resp2), .timeout(tmo2)
`ifdef RO_PUF_TIE_FLAG_EN
      , .tie(tie2)
`endif
   );

   always #5 clk = ~clk;

   // Oscillator models: square waves of pa / pb clk periods, 0 = tied low
   always @(negedge clk) begin
      if (pa == 0) begin
         ro_a = 1'b0; ph_a = 0;
      end else begin
         if (ph_a >= pa) ph_a = 0;
         ro_a = (ph_a < pa / 2);
         ph_a = ph_a + 1;
      end
      if (pb == 0) begin
         ro_b = 1'b0; ph_b = 0;
      end else begin
         if (ph_b >= pb) ph_b = 0;
         ro_b = (ph_b < pb / 2);
         ph_b = ph_b + 1;
      end
   end

   always @(negedge clk) begin
      if (st1 == 2'b11) done_cnt = done_cnt + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One measurement on dut1; caller is at a negedge with roen low
   task automatic run_meas(input int a, input int b, input bit er, input bit et);
      exp_t e;
      exp_t got;
      int   cyc;
      pa = a; pb = b;
      e.resp = er; e.tmo = et;
      sb.push_back(e);
      roen = 1'b1;
      @(negedge clk);
      check("count_entry", st1, 2'b01);
      cyc = 0;
      while (st1 != 2'b11 && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      if (st1 != 2'b11) begin
         check("done_wait", st1, 2'b11);
         void'(sb.pop_front());
      end else if (sb.size() == 0) begin
         check("sb_empty", 1, 0);
      end else begin
         got = sb.pop_front();
         check("resp_bit", resp1, got.resp);
         check("timeout", tmo1, got.tmo);
      end
      @(negedge clk);
      check("done_one_cycle", st1, 2'b10);
      roen = 1'b0;
      @(negedge clk);
      check("release_to_idle", st1, 2'b00);
   endtask

   initial begin
      int cyc;
      int base;
      int per[4];

      tbl[0] = '{pa: 4,  pb: 6, resp: 1'b1, tmo: 1'b0};
      tbl[1] = '{pa: 6,  pb: 4, resp: 1'b0, tmo: 1'b0};
      tbl[2] = '{pa: 4,  pb: 8, resp: 1'b1, tmo: 1'b0};
      tbl[3] = '{pa: 10, pb: 6, resp: 1'b0, tmo: 1'b0};
      tbl[4] = '{pa: 0,  pb: 0, resp: 1'b0, tmo: 1'b1};
      tbl[5] = '{pa: 6,  pb: 8, resp: 1'b1, tmo: 1'b0};
      per = '{4, 6, 8, 10};

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_state", st1, 2'b00);
      check("rst_resp", resp1, 1'b0);
      check("rst_timeout", tmo1, 1'b0);
      check("rst_cnt_a", dut1.cnt_a, 0);

      // Table-driven races on dut1
      for (int i = 0; i < 6; i++) run_meas(tbl[i].pa, tbl[i].pb, tbl[i].resp, tbl[i].tmo);

      // Exact timeout on dut2 with both oscillators tied low
      pa = 0; pb = 0;
      roen2 = 1'b1;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (st2 != 2'b11 && cyc < 200);
      check("tmo_latency", cyc, 51);
      check("tmo_resp", resp2, 1'b0);
      check("tmo_flag", tmo2, 1'b1);
`ifdef RO_PUF_TIE_FLAG_EN
      check("tmo_tie", tie2, 1'b1);
`endif
      @(negedge clk);
      check("tmo_release", st2, 2'b10);
      roen2 = 1'b0;
      @(negedge clk);
      check("tmo_idle", st2, 2'b00);
      // Timeout with A running: resp follows the counts
      pa = 4;
      roen2 = 1'b1;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (st2 != 2'b11 && cyc < 200);
      check("tmo2_latency", cyc, 51);
      check("tmo2_resp", resp2, 1'b1);
      check("tmo2_flag", tmo2, 1'b1);
`ifdef RO_PUF_TIE_FLAG_EN
      check("tmo2_tie", tie2, 1'b0);
`endif
      pa = 0;

      // Abort after 10 COUNT cycles on dut1
      pa = 4; pb = 6;
      roen = 1'b1;
      repeat (10) @(negedge clk);
      check("abort_counting", st1, 2'b01);
      roen = 1'b0;
      @(negedge clk);
      check("abort_idle", st1, 2'b00);
      check("abort_resp_kept", resp1, 1'b1);
      check("abort_tmo_kept", tmo1, 1'b0);
      @(negedge clk);
      check("abort_cnt_a", dut1.cnt_a, 0);
      check("abort_cnt_b", dut1.cnt_b, 0);
      check("abort_tmo_cnt", dut1.tmo, 0);

      // Synchronous reset mid-COUNT at cnt_a == 7
      roen = 1'b1;
      cyc = 0;
      while (dut1.cnt_a != 16'd7 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check("reach_cnt7", dut1.cnt_a, 7);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_state", st1, 2'b00);
      check("mid_rst_resp", resp1, 1'b0);
      check("mid_rst_tmo", tmo1, 1'b0);
      check("mid_rst_cnt_a", dut1.cnt_a, 0);
      check("mid_rst_cnt_b", dut1.cnt_b, 0);
      check("mid_rst_tmo_cnt", dut1.tmo, 0);
      check("mid_rst_state2", st2, 2'b00);
      check("mid_rst_resp2", resp2, 1'b0);
      check("mid_rst_tmo2", tmo2, 1'b0);
      rst = 1'b0;
      roen = 1'b0;
      roen2 = 1'b0;
      pa = 0; pb = 0;
      repeat (4) @(negedge clk);
      check("post_rst_idle", st1, 2'b00);

      // Closed loop: 128 back-to-back measurements with one-cycle roen gaps
      base = done_cnt;
      for (int k = 0; k < 128; k++) begin
         int i, j;
         i = $urandom_range(0, 3);
         j = (i + $urandom_range(1, 3)) % 4;
         run_meas(per[i], per[j], per[i] < per[j], 1'b0);
      end
      check("done_pulses", done_cnt - base, 128);
      check("sb_drained", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
